// File: rtl/poly_square_synth.sv
// Polyphonic PS/2-keyed square-wave synthesiser: scan-code parser, voice allocator,
// per-voice oscillators, fixed-rate mixer and saturating volume. Optional VOICE_STEAL_EN.
module poly_square_synth #(
  parameter int unsigned VOICES     = 4,
  parameter int unsigned SAMPLE_DIV = 1042,
  parameter logic [15:0] VOL_STEP   = 16'h0FFF,
  parameter int unsigned HP_SHIFT   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               data,
  input  logic                     valid_data,
  input  logic                     volume_plus,
  input  logic                     volume_minus,
  output logic signed [15:0]       square_wave,
  output logic                     wr,
  output logic [VOICES-1:0]        voice_busy,
  output logic [7:0]               last_key
);

  localparam int unsigned VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned LOG2V = $clog2(VOICES);
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {P_IDLE, P_BREAK, P_EXT, P_EXTBRK} pstate_e;

  function automatic logic [16:0] half_period(input logic [3:0] idx);
    logic [16:0] raw;
    case (idx)
      4'd0:    raw = 17'd95555;
      4'd1:    raw = 17'd90192;
      4'd2:    raw = 17'd85130;
      4'd3:    raw = 17'd80352;
      4'd4:    raw = 17'd75842;
      4'd5:    raw = 17'd71585;
      4'd6:    raw = 17'd67568;
      4'd7:    raw = 17'd63775;
      4'd8:    raw = 17'd60196;
      4'd9:    raw = 17'd56817;
      4'd10:   raw = 17'd53628;
      4'd11:   raw = 17'd50618;
      default: raw = '0;
    endcase
    return raw >> HP_SHIFT;
  endfunction

  pstate_e            p_state_q, p_state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        volume_q, volume_d;
  logic [15:0]        square_wave_q, square_wave_d;
  logic               wr_q, wr_d;
  logic [7:0]         last_key_q, last_key_d;
  logic [VOICES-1:0]  busy_q, busy_d;
  logic [VOICES-1:0]  phase_q, phase_d;
  logic [3:0]         key_q [VOICES];
  logic [3:0]         key_d [VOICES];
  logic [16:0]        cnt_q [VOICES];
  logic [16:0]        cnt_d [VOICES];
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]      steal_ptr_q, steal_ptr_d;
`endif

  logic               key_hit;
  logic [3:0]         key_idx;
  logic               note_on, note_off;
  logic               dup, free_found, load_en;
  logic [VW-1:0]      free_sel, load_sel;
  logic [VOICES-1:0]  wrap;
  logic               tick;
  logic [15:0]        amp, mix_val;
  logic [16:0]        vol_sum;

  always_comb begin
    key_hit = 1'b1;
    key_idx = '0;
    case (data)
      8'h15:   key_idx = 4'd0;
      8'h1D:   key_idx = 4'd1;
      8'h24:   key_idx = 4'd2;
      8'h2D:   key_idx = 4'd3;
      8'h2C:   key_idx = 4'd4;
      8'h35:   key_idx = 4'd5;
      8'h3C:   key_idx = 4'd6;
      8'h43:   key_idx = 4'd7;
      8'h44:   key_idx = 4'd8;
      8'h4D:   key_idx = 4'd9;
      8'h54:   key_idx = 4'd10;
      8'h5B:   key_idx = 4'd11;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    p_state_d = p_state_q;
    note_on   = 1'b0;
    note_off  = 1'b0;
    if (valid_data) begin
      unique case (p_state_q)
        P_IDLE: begin
          if (data == 8'hF0)      p_state_d = P_BREAK;
          else if (data == 8'hE0) p_state_d = P_EXT;
          else                    note_on   = key_hit;
        end
        P_BREAK: begin
          note_off  = key_hit;
          p_state_d = P_IDLE;
        end
        P_EXT:    p_state_d = (data == 8'hF0) ? P_EXTBRK : P_IDLE;
        P_EXTBRK: p_state_d = P_IDLE;
        default:  p_state_d = P_IDLE;
      endcase
    end
  end

  always_comb begin
    dup        = 1'b0;
    free_found = 1'b0;
    free_sel   = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (busy_q[v] && (key_q[v] == key_idx)) dup = 1'b1;
      if (!busy_q[v] && !free_found) begin
        free_found = 1'b1;
        free_sel   = VW'(v);
      end
    end
  end

  always_comb begin
    load_en  = 1'b0;
    load_sel = free_sel;
`ifdef VOICE_STEAL_EN
    steal_ptr_d = steal_ptr_q;
`endif
    if (note_on && !dup) begin
      if (free_found) begin
        load_en = 1'b1;
      end
`ifdef VOICE_STEAL_EN
      else begin
        load_en     = 1'b1;
        load_sel    = steal_ptr_q;
        steal_ptr_d = (steal_ptr_q == VW'(VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < VOICES; v++) begin
      wrap[v] = ({1'b0, cnt_q[v]} + 18'd1) >= {1'b0, half_period(key_q[v])};
    end
  end

  // Oscillators advance first; a load or release on the same edge overrides that voice.
  always_comb begin
    busy_d     = busy_q;
    phase_d    = phase_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    last_key_d = last_key_q;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (busy_q[v]) begin
        if (wrap[v]) begin
          cnt_d[v]   = '0;
          phase_d[v] = ~phase_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] + 17'd1;
        end
      end else begin
        cnt_d[v]   = '0;
        phase_d[v] = 1'b0;
      end
      if (load_en && (VW'(v) == load_sel)) begin
        busy_d[v]  = 1'b1;
        key_d[v]   = key_idx;
        cnt_d[v]   = '0;
        phase_d[v] = 1'b0;
      end
      if (note_off && busy_q[v] && (key_q[v] == key_idx)) begin
        busy_d[v]  = 1'b0;
        cnt_d[v]   = '0;
        phase_d[v] = 1'b0;
      end
    end
    if (load_en) last_key_d = data;
  end

  assign amp = volume_q >> (LOG2V + 1);

  always_comb begin
    mix_val = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (busy_q[v]) mix_val = phase_q[v] ? (mix_val + amp) : (mix_val - amp);
    end
  end

  assign tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign vol_sum = {1'b0, volume_q} + {1'b0, VOL_STEP};

  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    wr_d          = tick;
    square_wave_d = tick ? mix_val : square_wave_q;
    volume_d      = volume_q;
    if (volume_plus && !volume_minus) begin
      volume_d = vol_sum[16] ? '1 : vol_sum[15:0];
    end else if (volume_minus && !volume_plus) begin
      volume_d = (volume_q < VOL_STEP) ? '0 : volume_q - VOL_STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state_q     <= P_IDLE;
      div_q         <= '0;
      volume_q      <= 16'h3FFF;
      square_wave_q <= '0;
      wr_q          <= 1'b0;
      last_key_q    <= '0;
      busy_q        <= '0;
      phase_q       <= '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        key_q[v] <= '0;
        cnt_q[v] <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
`endif
    end else begin
      p_state_q     <= p_state_d;
      div_q         <= div_d;
      volume_q      <= volume_d;
      square_wave_q <= square_wave_d;
      wr_q          <= wr_d;
      last_key_q    <= last_key_d;
      busy_q        <= busy_d;
      phase_q       <= phase_d;
      for (int unsigned v = 0; v < VOICES; v++) begin
        key_q[v] <= key_d[v];
        cnt_q[v] <= cnt_d[v];
      end
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= steal_ptr_d;
`endif
    end
  end

  assign square_wave = square_wave_q;
  assign wr          = wr_q;
  assign voice_busy  = busy_q;
  assign last_key    = last_key_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Bench for poly_square_synth: directed key sequences plus random bytes/volume pulses,
// checked against a time-based reference model (phase derived from note start time).
module tb_poly_square_synth;

  localparam int unsigned NV  = 4;
  localparam int unsigned SD  = 4;
  localparam int unsigned HPS = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        data = '0;
  logic              valid_data = 1'b0;
  logic              volume_plus = 1'b0;
  logic              volume_minus = 1'b0;
  logic signed [15:0] square_wave;
  logic              wr;
  logic [NV-1:0]     voice_busy;
  logic [7:0]        last_key;

  poly_square_synth #(
    .VOICES(NV), .SAMPLE_DIV(SD), .VOL_STEP(16'h0FFF), .HP_SHIFT(HPS)
  ) dut (
    .clock(clock), .reset(reset), .data(data), .valid_data(valid_data),
    .volume_plus(volume_plus), .volume_minus(volume_minus),
    .square_wave(square_wave), .wr(wr), .voice_busy(voice_busy), .last_key(last_key)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] key_codes [12] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
                                 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B};
  int hp_full [12] = '{95555, 90192, 85130, 80352, 75842, 71585,
                       67568, 63775, 60196, 56817, 53628, 50618};

  // Model: a voice is (key, start edge); its phase at any edge is elapsed/hp mod 2.
  int         m_n, m_vol, m_steal;
  bit         m_after_f0, m_after_e0, m_after_e0f0;
  logic [7:0] m_last;
  logic [15:0] m_sq;
  bit         m_busy [NV];
  int         m_idx [NV];
  int         m_start [NV];

  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 12; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic int model_mix(input int t);
    int amp = m_vol >> (1 + $clog2(NV));
    int s = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_busy[v]) begin
        if ((((t - m_start[v]) / (hp_full[m_idx[v]] >> HPS)) % 2) == 1) s += amp;
        else s -= amp;
      end
    end
    return s;
  endfunction

  function automatic logic [NV-1:0] model_busy();
    logic [NV-1:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_busy[v];
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_vol = 16'h3FFF; m_steal = 0; m_last = '0; m_sq = '0;
    m_after_f0 = 0; m_after_e0 = 0; m_after_e0f0 = 0;
    for (int v = 0; v < NV; v++) begin
      m_busy[v] = 0; m_idx[v] = 0; m_start[v] = 0;
    end
  endtask

  task automatic model_note_on(input int k, input logic [7:0] b);
    int tgt = -1;
    for (int v = 0; v < NV; v++) if (m_busy[v] && m_idx[v] == k) return;
    for (int v = NV - 1; v >= 0; v--) if (!m_busy[v]) tgt = v;
`ifdef VOICE_STEAL_EN
    if (tgt < 0) begin
      tgt = m_steal;
      m_steal = (m_steal + 1) % NV;
    end
`endif
    if (tgt < 0) return;
    m_busy[tgt] = 1; m_idx[tgt] = k; m_start[tgt] = m_n; m_last = b;
  endtask

  task automatic model_edge(input logic [7:0] b, input bit v, input bit vp, input bit vm,
                            output bit exp_wr);
    int k;
    m_n++;
    exp_wr = (m_n % SD) == 0;
    if (exp_wr) m_sq = 16'(model_mix(m_n - 1));
    if (v) begin
      k = key_index(b);
      if (m_after_f0) begin
        if (k >= 0) for (int i = 0; i < NV; i++) if (m_busy[i] && m_idx[i] == k) m_busy[i] = 0;
        m_after_f0 = 0;
      end else if (m_after_e0) begin
        m_after_e0 = 0;
        m_after_e0f0 = (b == 8'hF0);
      end else if (m_after_e0f0) begin
        m_after_e0f0 = 0;
      end else if (b == 8'hF0) m_after_f0 = 1;
      else if (b == 8'hE0) m_after_e0 = 1;
      else if (k >= 0) model_note_on(k, b);
    end
    if (vp && !vm) m_vol = (m_vol + 16'h0FFF > 65535) ? 65535 : m_vol + 16'h0FFF;
    if (vm && !vp) m_vol = (m_vol < 16'h0FFF) ? 0 : m_vol - 16'h0FFF;
  endtask

  task automatic step(input logic [7:0] b, input bit v, input bit vp, input bit vm);
    bit exp_wr;
    data = b; valid_data = v; volume_plus = vp; volume_minus = vm;
    @(posedge clock);
    #1;
    model_edge(b, v, vp, vm, exp_wr);
    check("wr", {31'd0, wr}, {31'd0, exp_wr});
    check("sample", {16'd0, square_wave}, {16'd0, m_sq});
    check("voice_busy", {28'd0, voice_busy}, {28'd0, model_busy()});
    check("last_key", {24'd0, last_key}, {24'd0, m_last});
    @(negedge clock);
    valid_data = 1'b0; volume_plus = 1'b0; volume_minus = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(b, 1'b1, 1'b0, 1'b0);
    idle(gap);
  endtask

  task automatic do_reset(input bit immediate);
    reset = 1'b1;
    if (immediate) #1;
    else begin
      repeat (2) @(posedge clock);
      #1;
    end
    check("rst_busy", {28'd0, voice_busy}, 32'd0);
    check("rst_sample", {16'd0, square_wave}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_last_key", {24'd0, last_key}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);
    idle(12);

    send(8'h15, 60);
    check("t2_busy", {28'd0, voice_busy}, 32'h1);
    check("t2_last", {24'd0, last_key}, 32'h15);

    send(8'h1D, 10);
    check("t3_busy_a", {28'd0, voice_busy}, 32'h3);
    send(8'hF0, 0); send(8'h15, 10);
    check("t3_busy_b", {28'd0, voice_busy}, 32'h2);
    send(8'h15, 10);
    check("t3_busy_c", {28'd0, voice_busy}, 32'h3);
    send(8'hF0, 0); send(8'h15, 0); send(8'hF0, 0); send(8'h1D, 5);

    send(8'h15, 3); send(8'h15, 3); send(8'h15, 3);
    check("t4_busy_a", {28'd0, voice_busy}, 32'h1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h15, 5);
    check("t4_busy_b", {28'd0, voice_busy}, 32'h1);

    send(8'h15, 2); send(8'h1D, 2); send(8'h24, 2); send(8'h2D, 2); send(8'h2C, 30);
    check("t5_busy", {28'd0, voice_busy}, 32'hF);
`ifdef VOICE_STEAL_EN
    check("t5_last", {24'd0, last_key}, 32'h2C);
`else
    check("t5_last", {24'd0, last_key}, 32'h2D);
`endif

    repeat (16) step(8'h00, 1'b0, 1'b1, 1'b0);
    idle(8);
    step(8'h00, 1'b0, 1'b1, 1'b1);
    idle(8);
    do_reset(1'b1);
    idle(6);

    send(8'hF0, 0);
    do_reset(1'b1);
    send(8'h15, 10);
    check("brk_reset_busy", {28'd0, voice_busy}, 32'h1);
    repeat (6) step(8'h00, 1'b0, 1'b0, 1'b1);
    idle(8);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] b;
      bit v, vp, vm;
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      b = key_codes[$urandom_range(0, 11)];
      else if (r <= 7) b = 8'hF0;
      else if (r == 8) b = 8'hE0;
      else             b = 8'($urandom);
      v  = ($urandom_range(0, 3) == 0);
      vp = ($urandom_range(0, 24) == 0);
      vm = ($urandom_range(0, 24) == 0);
      if (i == 1000) do_reset(1'b1);
      step(b, v, vp, vm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
